// File: rtl/bus_interface_unit_pkg.sv
// Shared definitions for the 6502 external memory path: widths, state encoding
// and the data value that registers take on reset.
package bus_interface_unit_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 8;
    localparam int CNT_W          = 8;

    localparam logic [7:0] RESET_DATA = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } biu_state_e;

endpackage

// File: rtl/bus_interface_unit_cycle_counter.sv
// Loadable 8-bit up-counter with synchronous clear and a terminal-count compare,
// used for both the address setup phase and the ready timeout.
module biu_cycle_counter
    import bus_interface_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             at_terminal
);

    logic [CNT_W-1:0] count;

    // Clear has priority over load, load over counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/bus_interface_unit.sv
// Sequences one external memory read or write per request, with programmable
// address setup, ready-driven wait states and a timeout abort.
module bus_interface_unit
    import bus_interface_unit_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] mdr_data,
    output logic              mdr_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    biu_state_e state;
    logic       we_q;

    logic setup_load, setup_enable, setup_term;
    logic wait_clear, wait_enable, wait_term;

    // Setup counter runs 1..SETUP_CYCLES; the wait counter counts ready-low ACCESS cycles from 0.
    assign setup_load   = (state == ST_IDLE) && req;
    assign setup_enable = (state == ST_SETUP) && !setup_term;
    assign wait_clear   = (state == ST_SETUP) && setup_term;
    assign wait_enable  = (state == ST_ACCESS) && !mem_ready && !wait_term;

    biu_cycle_counter u_setup_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (1'b0),
        .load       (setup_load),
        .load_value (CNT_W'(1)),
        .enable     (setup_enable),
        .terminal   (CNT_W'(SETUP_CYCLES)),
        .at_terminal(setup_term)
    );

    biu_cycle_counter u_wait_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (wait_clear),
        .load       (1'b0),
        .load_value ('0),
        .enable     (wait_enable),
        .terminal   (CNT_W'(TIMEOUT)),
        .at_terminal(wait_term)
    );

    // Outputs are registered alongside the state, so each is set on entry to the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mdr_data  <= DATA_W'(RESET_DATA);
            mdr_load  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= DATA_W'(RESET_DATA);
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            mdr_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_SETUP;
                        busy      <= 1'b1;
                        we_q      <= req_we;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                    end
                end
                ST_SETUP: begin
                    if (setup_term) begin
                        state  <= ST_ACCESS;
                        mem_oe <= !we_q;
                        mem_we <= we_q;
                    end
                end
                ST_ACCESS: begin
                    // Ready takes priority over the timeout when both land in the same cycle.
                    if (mem_ready) begin
                        state  <= ST_DONE;
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        if (!we_q) begin
                            mdr_data <= mem_rdata;
                            mdr_load <= 1'b1;
                        end
                    end else if (wait_term) begin
                        state  <= ST_ERROR;
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    mem_oe <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit: directed transfer table, reset
// abort sequence and randomized transfers against a transaction-level model.
module tb_bus_interface_unit;

    localparam int S   = 1;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        busy, done, err, mdr_load, mem_oe, mem_we;
    logic [7:0]  mdr_data, mem_wdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;

    bus_interface_unit #(
        .ADDR_W      (16),
        .DATA_W      (8),
        .SETUP_CYCLES(S),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mdr_data (mdr_data),
        .mdr_load (mdr_load),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          waits;
        bit          hold_req;
        bit          exp_done;
        int          exp_latency;
        logic [7:0]  exp_mdr;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [0:65535];
    logic [7:0] ref_mdr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Transaction-level prediction: a transfer completes if ready comes within TMO waits.
    function automatic vec_t predict(vec_t v);
        vec_t r = v;
        r.exp_done    = (v.waits <= TMO);
        r.exp_latency = r.exp_done ? S + v.waits + 2 : S + TMO + 2;
        r.exp_mdr     = (r.exp_done && !v.we) ? ref_mem[v.addr] : ref_mdr;
        return r;
    endfunction

    task automatic commitModel(input vec_t v);
        if (v.exp_done) begin
            if (v.we) ref_mem[v.addr] = v.wdata;
            else      ref_mdr = ref_mem[v.addr];
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat = 0, oe_n = 0, we_n = 0, loads = 0, acc = 0, exp_strobe;
        bit saw_done = 0, saw_err = 0, addr_ok = 1, wdata_ok = 1, both = 0, load_with_done = 0;
        logic [7:0] mdr_at_end = '0;
        @(negedge clk);
        checkOutput("idle quiet", {busy, done, err, mdr_load, mem_oe, mem_we}, 0);
        req = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; mem_ready = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= S + TMO + 10; c++) begin
            @(negedge clk);
            if (v.hold_req) begin
                req = 1'b1; req_we = ~v.we; req_addr = ~v.addr; req_wdata = ~v.wdata;
            end else begin
                req = 1'b0; req_addr = 16'($urandom); req_wdata = 8'($urandom);
            end
            if (mem_oe) oe_n++;
            if (mem_we) we_n++;
            if (mem_oe && mem_we) both = 1;
            if ((mem_oe || mem_we) && mem_addr !== v.addr) addr_ok = 0;
            if (mem_we && mem_wdata !== v.wdata) wdata_ok = 0;
            if (mdr_load) loads++;
            if (done || err) begin
                lat = c; saw_done = done; saw_err = err;
                load_with_done = mdr_load; mdr_at_end = mdr_data;
                break;
            end
            if (mem_oe || mem_we) begin
                acc++;
                mem_ready = (acc == v.waits + 1);
                mem_rdata = mem_ready ? ref_mem[v.addr] : 8'($urandom);
            end else begin
                mem_ready = 1'b0;
            end
        end
        mem_ready = 1'b0;
        exp_strobe = v.exp_done ? v.waits + 1 : TMO + 1;
        checkOutput("outcome done/err", {saw_done, saw_err}, v.exp_done ? 2'b10 : 2'b01);
        checkOutput("latency", lat, v.exp_latency);
        checkOutput(v.we ? "mem_we cycles" : "mem_oe cycles", v.we ? we_n : oe_n, exp_strobe);
        checkOutput("wrong strobe", 32'(both) + (v.we ? oe_n : we_n), 0);
        checkOutput("mdr_load pulses", loads, (v.exp_done && !v.we) ? 1 : 0);
        checkOutput("mdr_load with done", load_with_done, (v.exp_done && !v.we) ? 1 : 0);
        checkOutput("mdr_data", mdr_at_end, v.exp_mdr);
        checkOutput("mem_addr held", addr_ok, 1);
        checkOutput("mem_wdata held", wdata_ok, 1);
        commitModel(v);
    endtask

    vec_t table_v [7];
    vec_t rv;
    bit   noisy;

    initial begin
        for (int a = 0; a < 65536; a++) ref_mem[a] = 8'h00;
        for (int a = 16'h0300; a < 16'h0310; a++) ref_mem[a] = 8'($urandom);
        ref_mem[16'hFFFC] = 8'h4C;
        ref_mem[16'h0000] = 8'h11;
        ref_mem[16'h0001] = 8'h22;
        ref_mem[16'h0301] = 8'h5A;
        ref_mdr = 8'h00;

        //                we    addr      wdata  waits hold done lat mdr
        table_v[0] = '{1'b0, 16'hFFFC, 8'h00, 0,   1'b0, 1'b1, 3,  8'h4C};
        table_v[1] = '{1'b1, 16'h0200, 8'hA5, 3,   1'b0, 1'b1, 6,  8'h4C};
        table_v[2] = '{1'b0, 16'h0300, 8'h00, 99,  1'b0, 1'b0, 18, 8'h4C};
        table_v[3] = '{1'b0, 16'h0301, 8'h00, 15,  1'b0, 1'b1, 18, 8'h5A};
        table_v[4] = '{1'b0, 16'h0000, 8'h00, 0,   1'b1, 1'b1, 3,  8'h11};
        table_v[5] = '{1'b0, 16'h0001, 8'h00, 0,   1'b0, 1'b1, 3,  8'h22};
        table_v[6] = '{1'b0, 16'h0200, 8'h00, 1,   1'b0, 1'b1, 4,  8'hA5};

        repeat (3) @(negedge clk);
        checkOutput("reset controls", {busy, done, err, mdr_load, mem_oe, mem_we}, 0);
        checkOutput("reset buses", {mem_addr, mem_wdata, mdr_data}, 0);
        reset_n = 1'b1;

        foreach (table_v[i]) applyStimulus(table_v[i]);

        // Reset asserted while a read is waiting in ACCESS.
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_addr = 16'h0305; mem_ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("oe before reset", mem_oe, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid-access reset controls", {busy, done, err, mdr_load, mem_oe, mem_we}, 0);
        checkOutput("mid-access reset buses", {mem_addr, mem_wdata, mdr_data}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ref_mdr = 8'h00;
        noisy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done || err || mdr_load || mem_oe || mem_we) noisy = 1;
        end
        checkOutput("post-reset quiet", noisy, 0);

        for (int n = 0; n < 40; n++) begin
            rv.we       = 1'($urandom_range(0, 1));
            rv.addr     = 16'h0300 | 16'($urandom_range(0, 15));
            rv.wdata    = 8'($urandom);
            rv.waits    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
            rv.hold_req = 1'($urandom_range(0, 1));
            applyStimulus(predict(rv));
        end

        @(negedge clk);
        checkOutput("final idle", {busy, done, err, mdr_load, mem_oe, mem_we}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
